// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned BE_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    // Request captured when the access is launched; drives the bus while BUSY.
    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  data;
        mem_size_t          sz;
        logic               rd;
        logic               wr;
        logic               llsc;
        logic               sext;
    } mem_req_t;

    // Big-endian byte enables: BE[3] covers bits 31:24 (lowest byte address).
    function automatic logic [BE_W-1:0] be_gen(input mem_size_t sz, input logic [1:0] addr_lo);
        logic [BE_W-1:0] be;
        case (sz)
            BYTE:    be = 4'b1000 >> addr_lo;
            HALF:    be = addr_lo[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store-data replication and load lane select with extension.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  mem_size_t         st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] st_rep_c,
    input  mem_size_t         ld_size,
    input  logic [BE_W-1:0]   ld_be,
    input  logic              ld_sext,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        case (st_size)
            BYTE:    st_rep_c = {4{st_data[7:0]}};
            HALF:    st_rep_c = {2{st_data[15:0]}};
            default: st_rep_c = st_data;
        endcase
    end

    // Lane chosen from the byte enables so the address never has to travel with the data.
    always_comb begin
        case (ld_be)
            4'b1000: lane8 = ld_word[31:24];
            4'b0100: lane8 = ld_word[23:16];
            4'b0010: lane8 = ld_word[15:8];
            default: lane8 = ld_word[7:0];
        endcase
        lane16 = ld_be[3] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            BYTE:    ld_data_c = ld_sext ? {{24{lane8[7]}}, lane8} : {24'b0, lane8};
            HALF:    ld_data_c = ld_sext ? {{16{lane16[15]}}, lane16} : {16'b0, lane16};
            default: ld_data_c = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: alignment check, req/ready bus handshake,
// pipeline stall, bus timeout and LL/SC link tracking.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic        M_MemHalf,
    input  logic        M_MemByte,
    input  logic        M_MemSignExtend,
    input  logic        M_LLSC,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] M_ReadData2,
    input  logic        M_Flush,
    input  logic        DataMem_Ready,
    input  logic [31:0] DataMem_In,
    output logic        DataMem_Read,
    output logic        DataMem_Write,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic [3:0]  DataMem_BE,
    output logic        M_Stall,
    output logic [31:0] M_ReadData,
    output logic        M_AddrErrLoad,
    output logic        M_AddrErrStore,
    output logic        M_BusErr
);
    import mem_ctrl_pkg::*;

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              link_q, link_d;
    logic              discard_q, discard_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    mem_size_t         cur_size;
    logic              misaligned;
    logic              req;
    logic              busy;
    logic              kill;
    logic [DATA_W-1:0] st_rep;
    logic [DATA_W-1:0] ld_data;

    // Decode of the instruction currently in MEM.
    always_comb begin
        cur_size   = M_MemByte ? BYTE : (M_MemHalf ? HALF : WORD);
        misaligned = ((cur_size == HALF) && M_ALUResult[0]) ||
                     ((cur_size == WORD) && (M_ALUResult[1:0] != 2'b00));
    end

    assign req  = (M_MemRead | M_MemWrite) & ~misaligned & ~M_Flush &
                  ~(M_MemWrite & M_LLSC & ~link_q);
    assign busy = (state_q == BUSY);
    assign kill = discard_q | M_Flush;

    assign M_AddrErrLoad  = M_MemRead & misaligned;
    assign M_AddrErrStore = M_MemWrite & misaligned;

    assign DataMem_Read    = busy & req_q.rd;
    assign DataMem_Write   = busy & req_q.wr;
    assign DataMem_Address = busy ? req_q.addr : '0;
    assign DataMem_Out     = busy ? req_q.data : '0;
    assign DataMem_BE      = busy ? req_q.be : '0;

    mem_lane_align u_align (
        .st_size   (cur_size),
        .st_data   (M_ReadData2),
        .st_rep_c  (st_rep),
        .ld_size   (req_q.sz),
        .ld_be     (req_q.be),
        .ld_sext   (req_q.sext),
        .ld_word   (DataMem_In),
        .ld_data_c (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        link_d     = link_q;
        discard_d  = discard_q;
        timer_d    = '0;
        M_Stall    = 1'b0;
        M_BusErr   = 1'b0;
        M_ReadData = '0;
        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (req) begin
                    state_d    = BUSY;
                    M_Stall    = 1'b1;
                    req_d.addr = M_ALUResult[31:2];
                    req_d.be   = be_gen(cur_size, M_ALUResult[1:0]);
                    req_d.data = st_rep;
                    req_d.sz   = cur_size;
                    req_d.rd   = M_MemRead;
                    req_d.wr   = M_MemWrite;
                    req_d.llsc = M_LLSC;
                    req_d.sext = M_MemSignExtend;
                end
            end
            BUSY: begin
                M_Stall = ~DataMem_Ready;
                timer_d = timer_q + TMR_W'(1);
                if (M_Flush) begin
                    discard_d = 1'b1;
                end
                if (DataMem_Ready) begin
                    state_d = IDLE;
                    timer_d = '0;
                    // A flushed access finishes on the bus but leaves no architectural trace.
                    if (!kill) begin
                        if (req_q.rd) begin
                            M_ReadData = ld_data;
                            if (req_q.llsc) begin
                                link_d = 1'b1;
                            end
                        end
                        if (req_q.wr && req_q.llsc) begin
                            M_ReadData = 32'd1;
                            link_d     = 1'b0;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    M_Stall  = 1'b0;
                    M_BusErr = 1'b1;
                    link_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (M_Flush) begin
            link_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            req_q     <= '0;
            link_q    <= 1'b0;
            discard_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            link_q    <= link_d;
            discard_q <= discard_d;
            timer_q   <= timer_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-addressed memory model, random
// instruction mix, bus responder with programmable wait states.
module tb_mem_access_ctrl;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        M_MemRead = 1'b0, M_MemWrite = 1'b0, M_MemHalf = 1'b0, M_MemByte = 1'b0;
    logic        M_MemSignExtend = 1'b0, M_LLSC = 1'b0, M_Flush = 1'b0;
    logic [31:0] M_ALUResult = '0, M_ReadData2 = '0;
    logic        DataMem_Ready;
    logic [31:0] DataMem_In;
    logic        DataMem_Read, DataMem_Write, M_Stall, M_AddrErrLoad, M_AddrErrStore, M_BusErr;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out, M_ReadData;
    logic [3:0]  DataMem_BE;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemHalf(M_MemHalf),
        .M_MemByte(M_MemByte), .M_MemSignExtend(M_MemSignExtend), .M_LLSC(M_LLSC),
        .M_ALUResult(M_ALUResult), .M_ReadData2(M_ReadData2), .M_Flush(M_Flush),
        .DataMem_Ready(DataMem_Ready), .DataMem_In(DataMem_In),
        .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
        .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out), .DataMem_BE(DataMem_BE),
        .M_Stall(M_Stall), .M_ReadData(M_ReadData),
        .M_AddrErrLoad(M_AddrErrLoad), .M_AddrErrStore(M_AddrErrStore), .M_BusErr(M_BusErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          ael;
        bit          aes;
        bit          berr;
        int          stalls;
    } ret_exp_t;

    bus_exp_t   bus_q[$];
    ret_exp_t   ret_q[$];
    logic [7:0] mdl_mem [64];
    logic [7:0] bus_mem [64];
    bit         m_link = 1'b0;
    bit         tb_valid = 1'b0;
    int         plan_wait = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         stall_cnt = 0;
    bus_exp_t   eb;
    ret_exp_t   er;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: answers after plan_wait BUSY cycles, backed by its own memory copy.
    initial begin
        int idx;
        int rcnt;
        rcnt = 0;
        DataMem_Ready = 1'b0;
        DataMem_In = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (DataMem_Read || DataMem_Write) begin
                idx = int'({DataMem_Address[3:0], 2'b00});
                if (DataMem_Read)
                    DataMem_In = {bus_mem[idx], bus_mem[idx+1], bus_mem[idx+2], bus_mem[idx+3]};
                if (rcnt == plan_wait) begin
                    DataMem_Ready = 1'b1;
                    if (DataMem_Write)
                        for (int k = 0; k < 4; k++)
                            if (DataMem_BE[3-k]) bus_mem[idx+k] = DataMem_Out[31-8*k -: 8];
                end else begin
                    DataMem_Ready = 1'b0;
                end
                rcnt++;
            end else begin
                DataMem_Ready = 1'b0;
                rcnt = 0;
            end
        end
    end

    // Monitor: pops expectations on bus completion and on instruction retirement.
    always @(negedge CLK) begin
        if (RST) begin
            if ((DataMem_Read || DataMem_Write) && DataMem_Ready) begin
                if (bus_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bus_unexpected: got access addr=0x%08h, expected none", DataMem_Address);
                end else begin
                    eb = bus_q.pop_front();
                    check("bus_read", 32'(DataMem_Read), 32'(eb.rd));
                    check("bus_write", 32'(DataMem_Write), 32'(eb.wr));
                    check("bus_addr", 32'(DataMem_Address), 32'(eb.addr));
                    check("bus_be", 32'(DataMem_BE), 32'(eb.be));
                    if (eb.wr) check("bus_wdata", DataMem_Out, eb.data);
                end
            end
            if (tb_valid) begin
                if (M_Stall) begin
                    stall_cnt++;
                end else begin
                    if (ret_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL retire_unexpected: got retirement, expected none");
                    end else begin
                        er = ret_q.pop_front();
                        check("stall_cycles", 32'(stall_cnt), 32'(er.stalls));
                        check("addr_err_load", 32'(M_AddrErrLoad), 32'(er.ael));
                        check("addr_err_store", 32'(M_AddrErrStore), 32'(er.aes));
                        check("bus_err", 32'(M_BusErr), 32'(er.berr));
                        if (er.chk_rdata) check("read_data", M_ReadData, er.rdata);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
        tb_valid = 1'b0;
        {M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend, M_LLSC, M_Flush} = '0;
    endtask

    // Reference model for one instruction, then drive it and wait for it to leave MEM.
    task automatic issue(input bit rd, input bit wr, input bit half, input bit byt, input bit sext,
                         input bit llsc, input logic [31:0] a, input logic [31:0] d, input int wt,
                         input bit flush_all, input bit flush_mid);
        int n, i, p;
        bit mis, req, tmo, done;
        logic [31:0] v;
        ret_exp_t r;
        bus_exp_t b;
        n   = byt ? 1 : (half ? 2 : 4);
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        req = (rd || wr) && !mis && !flush_all && !(wr && llsc && !m_link);
        tmo = req && (wt >= TMO);
        r.rdata = '0; r.chk_rdata = 1'b1; r.ael = rd && mis; r.aes = wr && mis;
        r.berr = 1'b0; r.stalls = 0;
        if (flush_all) m_link = 1'b0;
        if (tmo) begin
            r.berr = 1'b1; r.stalls = TMO; r.chk_rdata = 1'b0; m_link = 1'b0;
        end else if (req) begin
            r.stalls = wt + 1;
            i = int'(a[5:0]);
            b.rd = rd; b.wr = wr; b.addr = a[31:2]; b.be = '0;
            for (int k = 0; k < n; k++) begin
                p = int'(a[1:0]) + k;
                b.be[3-p] = 1'b1;
            end
            b.data = (n == 1) ? {4{d[7:0]}} : ((n == 2) ? {2{d[15:0]}} : d);
            bus_q.push_back(b);
            if (rd) begin
                v = '0;
                for (int k = 0; k < n; k++) v = (v << 8) | 32'(mdl_mem[i+k]);
                if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                r.rdata = v;
                if (llsc) m_link = 1'b1;
            end else begin
                for (int k = 0; k < n; k++) mdl_mem[i+k] = d[8*(n-1-k) +: 8];
                if (llsc) begin r.rdata = 32'd1; m_link = 1'b0; end
                else r.chk_rdata = 1'b0;
            end
            if (flush_mid) begin r.chk_rdata = 1'b0; m_link = 1'b0; end
        end
        ret_q.push_back(r);

        @(posedge CLK);
        #1;
        M_MemRead = rd; M_MemWrite = wr; M_MemHalf = half; M_MemByte = byt;
        M_MemSignExtend = sext; M_LLSC = llsc; M_ALUResult = a; M_ReadData2 = d;
        M_Flush = flush_all;
        plan_wait = req ? wt : 0;
        tb_valid = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!M_Stall) begin done = 1'b1; break; end
            @(posedge CLK);
            #1;
            if (flush_mid) M_Flush = (c == 0);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL retire_timeout: got M_Stall still high after 40 cycles, expected release");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rd, wr, half, byt, llsc, fl;
        int kind, sz, n, wsel, wt;
        logic [31:0] a;

        for (int k = 0; k < 64; k++) begin
            mdl_mem[k] = 8'($urandom);
            bus_mem[k] = mdl_mem[k];
        end
        mdl_mem[0] = 8'hDE; mdl_mem[1] = 8'hAD; mdl_mem[2] = 8'hBE; mdl_mem[3] = 8'hEF;
        for (int k = 0; k < 4; k++) bus_mem[k] = mdl_mem[k];

        #12;
        check("rst_read", 32'(DataMem_Read), 32'd0);
        check("rst_write", 32'(DataMem_Write), 32'd0);
        check("rst_addr", 32'(DataMem_Address), 32'd0);
        check("rst_be", 32'(DataMem_BE), 32'd0);
        check("rst_stall", 32'(M_Stall), 32'd0);
        check("rst_buserr", 32'(M_BusErr), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        issue(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 0, 0, 0);           // LW 0xDEADBEEF
        issue(0, 1, 0, 0, 0, 0, 32'h100, 32'h0000_00F0, 1, 0, 0);   // SW
        issue(1, 0, 0, 1, 1, 0, 32'h103, 32'h0, 0, 0, 0);           // LB  -> 0xFFFFFFF0
        issue(1, 0, 0, 1, 0, 0, 32'h103, 32'h0, 2, 0, 0);           // LBU -> 0x000000F0
        issue(0, 1, 1, 0, 0, 0, 32'h102, 32'h1234_ABCD, 2, 0, 0);   // SH lane 0011
        issue(1, 0, 1, 0, 1, 0, 32'h102, 32'h0, 0, 0, 0);           // LH signed
        issue(1, 0, 0, 0, 0, 0, 32'h101, 32'h0, 0, 0, 0);           // misaligned LW
        issue(0, 1, 1, 0, 0, 0, 32'h001, 32'h0, 0, 0, 0);           // misaligned SH
        issue(1, 0, 0, 0, 0, 1, 32'h110, 32'h0, 1, 0, 0);           // LL
        issue(0, 1, 0, 0, 0, 1, 32'h110, 32'hCAFE_0001, 0, 0, 0);   // SC ok
        issue(0, 1, 0, 0, 0, 1, 32'h110, 32'hCAFE_0002, 0, 0, 0);   // SC fails
        issue(1, 0, 0, 0, 0, 1, 32'h110, 32'h0, 0, 0, 0);           // LL
        issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);             // flush
        issue(0, 1, 0, 0, 0, 1, 32'h110, 32'hCAFE_0003, 0, 0, 0);   // SC fails
        issue(1, 0, 0, 0, 0, 1, 32'h114, 32'h0, 3, 0, 1);           // LL flushed mid-access
        issue(0, 1, 0, 0, 0, 1, 32'h114, 32'hCAFE_0004, 0, 0, 0);   // SC fails
        issue(1, 0, 0, 0, 0, 0, 32'h118, 32'h0, TMO - 1, 0, 0);     // Ready on last cycle
        issue(1, 0, 0, 0, 0, 1, 32'h118, 32'h0, 0, 0, 0);           // LL
        issue(1, 0, 0, 0, 0, 0, 32'h11C, 32'h0, TMO + 5, 0, 0);     // timeout
        issue(0, 1, 0, 0, 0, 1, 32'h118, 32'hCAFE_0005, 0, 0, 0);   // SC fails after BusErr

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            sz   = $urandom_range(0, 2);
            rd   = (kind < 4);
            wr   = (kind >= 4 && kind < 8);
            llsc = (rd || wr) && ($urandom_range(0, 3) == 0);
            if (llsc) sz = 2;
            byt  = (sz == 0);
            half = (sz == 1);
            n    = byt ? 1 : (half ? 2 : 4);
            a    = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) != 0) a = a & ~32'(n - 1);
            wsel = $urandom_range(0, 15);
            wt   = (wsel < 12) ? $urandom_range(0, 3) : ((wsel < 14) ? TMO - 1 : TMO + 5);
            fl   = ($urandom_range(0, 15) == 0);
            issue(rd, wr, half, byt, 1'($urandom), llsc, a, $urandom, wt, fl, 0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset during BUSY drops the strobes asynchronously and clears the link.
        issue(1, 0, 0, 0, 0, 1, 32'h120, 32'h0, 0, 0, 0);
        @(posedge CLK);
        #1;
        tb_valid = 1'b0;
        M_MemRead = 1'b1; M_MemWrite = 1'b0; M_MemHalf = 1'b0; M_MemByte = 1'b0;
        M_LLSC = 1'b0; M_Flush = 1'b0; M_ALUResult = 32'h124;
        plan_wait = 50;
        @(posedge CLK);
        #1;
        check("busy_read_strobe", 32'(DataMem_Read), 32'd1);
        #2;
        RST = 1'b0;
        M_MemRead = 1'b0;
        #1;
        check("rst_mid_read", 32'(DataMem_Read), 32'd0);
        check("rst_mid_be", 32'(DataMem_BE), 32'd0);
        check("rst_mid_stall", 32'(M_Stall), 32'd0);
        m_link = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        issue(0, 1, 0, 0, 0, 1, 32'h120, 32'hCAFE_0006, 0, 0, 0);  // SC fails after reset
        issue(1, 0, 0, 0, 0, 0, 32'h120, 32'h0, 1, 0, 0);

        idle_cycle();
        repeat (3) @(posedge CLK);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
